// File: rtl/trap_csr_if.sv
// Trap/mret sequencer bus: core request side, redirect side and CSR access port.
// Pure wiring, no latency.
// No backpressure; the CSR file answers a read on the cycle after the strobe.
interface trap_csr_if #(
  parameter int DATA_W = 32
);
  logic              trap_req_i;
  logic [DATA_W-1:0] trap_cause_i;
  logic [DATA_W-1:0] trap_pc_i;
  logic              mret_req_i;
  logic              busy_o;
  logic              redirect_valid_o;
  logic [DATA_W-1:0] redirect_pc_o;
  logic [31:0]       csr_address_o;
  logic              csr_en_write_o;
  logic              csr_en_read_o;
  logic [DATA_W-1:0] csr_data_o;
  logic              csr_en_except_o;
  logic [DATA_W-1:0] csr_data_i;

  // The sequencer side.
  modport master (
    input  trap_req_i, trap_cause_i, trap_pc_i, mret_req_i, csr_data_i,
    output busy_o, redirect_valid_o, redirect_pc_o, csr_address_o,
           csr_en_write_o, csr_en_read_o, csr_data_o, csr_en_except_o
  );

  // The core / CSR register file side.
  modport slave (
    output trap_req_i, trap_cause_i, trap_pc_i, mret_req_i, csr_data_i,
    input  busy_o, redirect_valid_o, redirect_pc_o, csr_address_o,
           csr_en_write_o, csr_en_read_o, csr_data_o, csr_en_except_o
  );
endinterface

// File: rtl/trap_csr_sequencer.sv
// Trap entry / mret sequencer driving the machine-CSR port and the fetch redirect.
// Latency: trap redirect 8 cycles after the sampling edge, mret redirect after 6.
// No backpressure: requests are only accepted in IDLE, ignored while busy_o=1.
// Optional feature: define MTVEC_VECTORED_EN for vectored interrupt targets.
module trap_csr_sequencer #(
  parameter int          DATA_W       = 32,
  parameter logic [31:0] MSTATUS_ADDR = 32'h300,
  parameter logic [31:0] MTVEC_ADDR   = 32'h305,
  parameter logic [31:0] MEPC_ADDR    = 32'h341,
  parameter logic [31:0] MCAUSE_ADDR  = 32'h342
) (
  input logic        clk_i,
  input logic        rst_i,
  trap_csr_if.master bus
);

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_W_MEPC       = 4'd1;
  localparam logic [3:0] S_W_MCAUSE     = 4'd2;
  localparam logic [3:0] S_R_MSTATUS    = 4'd3;
  localparam logic [3:0] S_WAIT_MSTATUS = 4'd4;
  localparam logic [3:0] S_W_MSTATUS    = 4'd5;
  localparam logic [3:0] S_R_MTVEC      = 4'd6;
  localparam logic [3:0] S_WAIT_MTVEC   = 4'd7;
  localparam logic [3:0] S_R_MEPC       = 4'd8;
  localparam logic [3:0] S_WAIT_MEPC    = 4'd9;
  localparam logic [3:0] S_REDIRECT     = 4'd10;

  localparam logic [DATA_W-1:0] ALIGN_MASK = {{(DATA_W-2){1'b1}}, 2'b00};

  logic [3:0]        state_q, state_d;
  logic              is_trap_q, is_trap_d;   // shared mstatus states: trap vs mret flavour
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [DATA_W-1:0] pc_q, pc_d;             // trap PC, or mepc read back on mret
  logic [DATA_W-1:0] mstatus_q, mstatus_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [DATA_W-1:0] trap_mstatus, mret_mstatus;
  logic [DATA_W-1:0] trap_target;

  // mstatus rewrite for trap entry and mret, plus the trap target from mtvec.
  always_comb begin
    trap_mstatus        = mstatus_q;
    trap_mstatus[7]     = mstatus_q[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus        = mstatus_q;
    mret_mstatus[3]     = mstatus_q[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b00;
`ifdef MTVEC_VECTORED_EN
    if (bus.csr_data_i[1:0] == 2'b01 && cause_q[DATA_W-1])
      trap_target = (bus.csr_data_i & ALIGN_MASK) + {cause_q[DATA_W-3:0], 2'b00};
    else
      trap_target = bus.csr_data_i & ALIGN_MASK;
`else
    trap_target = bus.csr_data_i & ALIGN_MASK;
`endif
  end

  // Sequence control: request arbitration in IDLE, then a fixed walk of states.
  always_comb begin
    state_d       = state_q;
    is_trap_d     = is_trap_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    mstatus_d     = mstatus_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.trap_req_i) begin
          state_d   = S_W_MEPC;
          is_trap_d = 1'b1;
          cause_d   = bus.trap_cause_i;
          pc_d      = bus.trap_pc_i & ALIGN_MASK;
        end else if (bus.mret_req_i) begin
          state_d   = S_R_MEPC;
          is_trap_d = 1'b0;
        end
      end
      S_W_MEPC:       state_d = S_W_MCAUSE;
      S_W_MCAUSE:     state_d = S_R_MSTATUS;
      S_R_MSTATUS:    state_d = S_WAIT_MSTATUS;
      S_WAIT_MSTATUS: begin
        mstatus_d = bus.csr_data_i;
        state_d   = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        if (is_trap_q) begin
          state_d = S_R_MTVEC;
        end else begin
          redirect_pc_d = pc_q;
          state_d       = S_REDIRECT;
        end
      end
      S_R_MTVEC:      state_d = S_WAIT_MTVEC;
      S_WAIT_MTVEC: begin
        redirect_pc_d = trap_target;
        state_d       = S_REDIRECT;
      end
      S_R_MEPC:       state_d = S_WAIT_MEPC;
      S_WAIT_MEPC: begin
        pc_d    = bus.csr_data_i & ALIGN_MASK;
        state_d = S_R_MSTATUS;
      end
      S_REDIRECT:     state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any sequence in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      is_trap_q     <= 1'b0;
      cause_q       <= '0;
      pc_q          <= '0;
      mstatus_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      is_trap_q     <= is_trap_d;
      cause_q       <= cause_d;
      pc_q          <= pc_d;
      mstatus_q     <= mstatus_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // CSR port decode; address/data stay 0 unless a strobe is active, and
  // exception mode is never raised on writes since the CSR file would block them.
  always_comb begin
    bus.csr_address_o   = '0;
    bus.csr_en_write_o  = 1'b0;
    bus.csr_en_read_o   = 1'b0;
    bus.csr_data_o      = '0;
    bus.csr_en_except_o = 1'b0;
    bus.redirect_valid_o = 1'b0;
    case (state_q)
      S_W_MEPC: begin
        bus.csr_en_write_o = 1'b1;
        bus.csr_address_o  = MEPC_ADDR;
        bus.csr_data_o     = pc_q;
      end
      S_W_MCAUSE: begin
        bus.csr_en_write_o = 1'b1;
        bus.csr_address_o  = MCAUSE_ADDR;
        bus.csr_data_o     = cause_q;
      end
      S_R_MSTATUS: begin
        bus.csr_en_read_o   = 1'b1;
        bus.csr_address_o   = MSTATUS_ADDR;
        bus.csr_en_except_o = is_trap_q;
      end
      S_W_MSTATUS: begin
        bus.csr_en_write_o = 1'b1;
        bus.csr_address_o  = MSTATUS_ADDR;
        bus.csr_data_o     = is_trap_q ? trap_mstatus : mret_mstatus;
      end
      S_R_MTVEC: begin
        bus.csr_en_read_o   = 1'b1;
        bus.csr_address_o   = MTVEC_ADDR;
        bus.csr_en_except_o = 1'b1;
      end
      S_R_MEPC: begin
        bus.csr_en_read_o = 1'b1;
        bus.csr_address_o = MEPC_ADDR;
      end
      S_REDIRECT: bus.redirect_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_trap_csr_sequencer.sv
// Bench for trap_csr_sequencer: CSR-file responder, per-cycle expectation queue
// built from the access sequences, and literal checks of key results.
// Honours MTVEC_VECTORED_EN the same way as the design.
module tb_trap_csr_sequencer;

  localparam logic [31:0] A_MSTATUS = 32'h300;
  localparam logic [31:0] A_MTVEC   = 32'h305;
  localparam logic [31:0] A_MEPC    = 32'h341;
  localparam logic [31:0] A_MCAUSE  = 32'h342;

  typedef struct packed {
    logic        busy;
    logic        wr;
    logic        rd;
    logic        exc;
    logic        rv;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_csr_if #(.DATA_W(32)) bus ();

  trap_csr_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int s0 = 0;
  int rdir_idx = -1;
  int n_redir = 0;
  int wr_cycles = 0;
  int exc_viol = 0;
  logic [31:0] last_rpc = '0;
  logic [31:0] rpc_model = '0;
  logic [31:0] csr_mem [logic [31:0]];   // the CSR register file seen by the DUT
  logic [31:0] model_csr [logic [31:0]]; // the model's own view of the CSRs
  exp_t exp_q [$];
  logic pend = 1'b0;
  logic [31:0] pval = '0;

  function automatic exp_t mk(input logic wr, rd, exc, rv, input logic [31:0] addr, data, rpc);
    exp_t e;
    e.busy = 1'b1; e.wr = wr; e.rd = rd; e.exc = exc; e.rv = rv;
    e.addr = addr; e.data = data; e.rpc = rpc;
    return e;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic set_csr(input logic [31:0] a, input logic [31:0] v);
    csr_mem[a]   = v;
    model_csr[a] = v;
  endtask

  // Trap: expected CSR traffic and redirect, one entry per cycle after sampling.
  task automatic model_trap(input logic [31:0] cause, input logic [31:0] pc);
    logic [31:0] ms, nms, tvec, tgt;
    ms   = model_csr[A_MSTATUS];
    tvec = model_csr[A_MTVEC];
    nms  = (ms & ~32'h0000_1888) | 32'h0000_1800 | ((ms & 32'h8) << 4);
    tgt  = tvec & ~32'h3;
`ifdef MTVEC_VECTORED_EN
    if (tvec[1:0] == 2'b01 && cause[31]) tgt = tgt + ((cause & 32'h7fff_ffff) << 2);
`endif
    exp_q.push_back(mk(1, 0, 0, 0, A_MEPC,    pc & ~32'h3, rpc_model));
    exp_q.push_back(mk(1, 0, 0, 0, A_MCAUSE,  cause,       rpc_model));
    exp_q.push_back(mk(0, 1, 1, 0, A_MSTATUS, 0,           rpc_model));
    exp_q.push_back(mk(0, 0, 0, 0, 0,         0,           rpc_model));
    exp_q.push_back(mk(1, 0, 0, 0, A_MSTATUS, nms,         rpc_model));
    exp_q.push_back(mk(0, 1, 1, 0, A_MTVEC,   0,           rpc_model));
    exp_q.push_back(mk(0, 0, 0, 0, 0,         0,           rpc_model));
    exp_q.push_back(mk(0, 0, 0, 1, 0,         0,           tgt));
    rpc_model = tgt;
    model_csr[A_MEPC]    = pc & ~32'h3;
    model_csr[A_MCAUSE]  = cause;
    model_csr[A_MSTATUS] = nms;
  endtask

  task automatic model_mret();
    logic [31:0] ms, nms, tgt;
    ms  = model_csr[A_MSTATUS];
    nms = (ms & ~32'h0000_1888) | 32'h80 | ((ms & 32'h80) >> 4);
    tgt = model_csr[A_MEPC] & ~32'h3;
    exp_q.push_back(mk(0, 1, 0, 0, A_MEPC,    0,   rpc_model));
    exp_q.push_back(mk(0, 0, 0, 0, 0,         0,   rpc_model));
    exp_q.push_back(mk(0, 1, 0, 0, A_MSTATUS, 0,   rpc_model));
    exp_q.push_back(mk(0, 0, 0, 0, 0,         0,   rpc_model));
    exp_q.push_back(mk(1, 0, 0, 0, A_MSTATUS, nms, rpc_model));
    exp_q.push_back(mk(0, 0, 0, 1, 0,         0,   tgt));
    rpc_model = tgt;
    model_csr[A_MSTATUS] = nms;
  endtask

  task automatic run_trap(input logic [31:0] cause, input logic [31:0] pc,
                          input logic with_mret, input int mret_at, input int rst_at);
    @(posedge clk); #1;
    bus.trap_req_i = 1'b1; bus.trap_cause_i = cause; bus.trap_pc_i = pc;
    bus.mret_req_i = with_mret;
    @(posedge clk); #1;
    bus.trap_req_i = 1'b0; bus.mret_req_i = 1'b0;
    bus.trap_cause_i = '0; bus.trap_pc_i = '0;
    s0 = cyc; rdir_idx = -1;
    model_trap(cause, pc);
    for (int k = 1; k <= 12; k++) begin
      bus.mret_req_i = (k == mret_at);
      if (k == rst_at) begin
        rst = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
      end
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        rpc_model = '0;
      end
    end
    bus.mret_req_i = 1'b0;
  endtask

  task automatic run_mret();
    @(posedge clk); #1;
    bus.mret_req_i = 1'b1;
    @(posedge clk); #1;
    bus.mret_req_i = 1'b0;
    s0 = cyc; rdir_idx = -1;
    model_mret();
    repeat (10) begin @(posedge clk); #1; end
  endtask

  initial begin
    int r0;
    bus.trap_req_i = 1'b0; bus.trap_cause_i = '0; bus.trap_pc_i = '0;
    bus.mret_req_i = 1'b0; bus.csr_data_i = '0;
    set_csr(A_MTVEC, 32'h0000_1000);
    set_csr(A_MSTATUS, 32'h0000_0008);
    set_csr(A_MEPC, 32'h0);
    set_csr(A_MCAUSE, 32'h0);

    fork
      // Cycle counter and CSR read-data return, one cycle after the read strobe.
      forever begin
        @(posedge clk);
        cyc++;
        #1;
        bus.csr_data_i = pend ? pval : '0;
        pend = 1'b0;
      end
      // Per-cycle compare against the model, plus CSR file write/read capture.
      forever begin
        exp_t e, got;
        @(negedge clk);
        got.busy = bus.busy_o;           got.wr = bus.csr_en_write_o;
        got.rd = bus.csr_en_read_o;      got.exc = bus.csr_en_except_o;
        got.rv = bus.redirect_valid_o;   got.addr = bus.csr_address_o;
        got.data = bus.csr_data_o;       got.rpc = bus.redirect_pc_o;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin
          e = mk(0, 0, 0, 0, 0, 0, rpc_model);
          e.busy = 1'b0;
        end
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL cycle_cmp cyc=%0d got busy=%b wr=%b rd=%b exc=%b rv=%b addr=%h data=%h rpc=%h want busy=%b wr=%b rd=%b exc=%b rv=%b addr=%h data=%h rpc=%h",
                   cyc, got.busy, got.wr, got.rd, got.exc, got.rv, got.addr, got.data, got.rpc,
                   e.busy, e.wr, e.rd, e.exc, e.rv, e.addr, e.data, e.rpc);
        end
        if (bus.redirect_valid_o) begin
          n_redir++;
          last_rpc = bus.redirect_pc_o;
          rdir_idx = cyc - s0 + 1;
        end
        if (bus.csr_en_write_o) begin
          wr_cycles++;
          if (bus.csr_en_except_o) exc_viol++;
          csr_mem[bus.csr_address_o] = bus.csr_data_o;
        end
        if (bus.csr_en_read_o) begin
          pend = 1'b1;
          pval = csr_mem.exists(bus.csr_address_o) ? csr_mem[bus.csr_address_o] : '0;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic trap entry.
    run_trap(32'h2, 32'h0000_0404, 1'b0, 0, 0);
    check32("t1_mepc", csr_mem[A_MEPC], 32'h404);
    check32("t1_mcause", csr_mem[A_MCAUSE], 32'h2);
    check32("t1_mstatus", csr_mem[A_MSTATUS], 32'h0000_1880);
    check32("t1_redirect_pc", last_rpc, 32'h1000);
    check32("t1_redirect_cycle", rdir_idx, 8);

    // Return from trap.
    run_mret();
    check32("t2_mstatus", csr_mem[A_MSTATUS], 32'h0000_0088);
    check32("t2_redirect_pc", last_rpc, 32'h404);
    check32("t2_redirect_cycle", rdir_idx, 6);

    // Simultaneous trap+mret, then mret while busy.
    r0 = n_redir;
    run_trap(32'hB, 32'h0000_0800, 1'b1, 3, 0);
    check32("t3_redirect_count", n_redir - r0, 1);
    check32("t3_mepc", csr_mem[A_MEPC], 32'h800);
    check32("t3_mstatus", csr_mem[A_MSTATUS], 32'h0000_1880);
    check32("t3_redirect_cycle", rdir_idx, 8);

    // Reset during W_MSTATUS, then a normal trap.
    r0 = n_redir;
    run_trap(32'h3, 32'h0000_0100, 1'b0, 0, 5);
    check32("t4_abort_redirects", n_redir - r0, 0);
    check32("t4_abort_rpc", bus.redirect_pc_o, 32'h0);
    run_trap(32'h4, 32'h0000_0120, 1'b0, 0, 0);
    check32("t4_after_redirects", n_redir - r0, 1);
    check32("t4_after_pc", last_rpc, 32'h1000);

    // Vectored-mode mtvec with an interrupt cause.
    set_csr(A_MTVEC, 32'h0000_1001);
    run_trap(32'h8000_0007, 32'h0000_0300, 1'b0, 0, 0);
`ifdef MTVEC_VECTORED_EN
    check32("t5_vectored_pc", last_rpc, 32'h0000_101C);
`else
    check32("t5_direct_pc", last_rpc, 32'h0000_1000);
`endif

    // Misaligned PC is aligned before being saved.
    set_csr(A_MTVEC, 32'h0000_1000);
    run_trap(32'h5, 32'h0000_0203, 1'b0, 0, 0);
    check32("t6_mepc_aligned", csr_mem[A_MEPC], 32'h200);
    check32("t6_redirect_pc", last_rpc, 32'h1000);

    check32("except_on_write", exc_viol, 0);
    check32("write_cycles", wr_cycles, 19);
    check32("expect_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
